// File: rtl/tone_arbiter.sv
// tone_arbiter: four-note request arbiter driving a 32-entry sine ROM address.
// Requests resolve by fixed priority (C > D > E > G). The playing note only
// changes on a 31->0 address wrap, so every note plays whole waveform periods.
// Optional macro TONE_ARBITER_SYNC_EN: two-flop synchronizer per note input
// (request-to-PLAY latency 3 cycles). When undefined, each input is
// registered once (latency 2 cycles).
module tone_arbiter #(
  parameter logic [12:0] DIV_DO  = 13'd5972,
  parameter logic [12:0] DIV_RE  = 13'd5320,
  parameter logic [12:0] DIV_MI  = 13'd4738,
  parameter logic [12:0] DIV_SOL = 13'd3986
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic       do_nota,
  input  logic       re_nota,
  input  logic       mi_nota,
  input  logic       sol_nota,
  output logic [4:0] rom_addr,
  output logic       sample_tick,
  output logic       note_active,
  output logic [1:0] note_sel
);

  // Divisors below 2 would leave no room for a counter phase; clamp them.
  localparam logic [12:0] DO_EFF  = (DIV_DO  < 13'd2) ? 13'd2 : DIV_DO;
  localparam logic [12:0] RE_EFF  = (DIV_RE  < 13'd2) ? 13'd2 : DIV_RE;
  localparam logic [12:0] MI_EFF  = (DIV_MI  < 13'd2) ? 13'd2 : DIV_MI;
  localparam logic [12:0] SOL_EFF = (DIV_SOL < 13'd2) ? 13'd2 : DIV_SOL;

  // Terminal counter values: the counter wraps (and a sample step happens)
  // when it reaches DIV-1.
  localparam logic [12:0] TC_DO  = DO_EFF  - 13'd1;
  localparam logic [12:0] TC_RE  = RE_EFF  - 13'd1;
  localparam logic [12:0] TC_MI  = MI_EFF  - 13'd1;
  localparam logic [12:0] TC_SOL = SOL_EFF - 13'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bit index doubles as the note code: 0=C, 1=D, 2=E, 3=G.
  logic [3:0] req_raw;
  logic [3:0] req_sync;

  assign req_raw = {sol_nota, mi_nota, re_nota, do_nota};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req_in
`ifdef TONE_ARBITER_SYNC_EN
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchronizer: the first flop may go metastable, the second
      // gives it a full cycle to resolve before the arbiter sees it.
      always_ff @(posedge clk50mhz) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= req_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign req_sync[gi] = sync_reg;
`else
      logic in_reg;

      // Single input register: one cycle of capture ahead of the arbiter.
      always_ff @(posedge clk50mhz) begin
        if (rst) begin
          in_reg <= 1'b0;
        end else begin
          in_reg <= req_raw[gi];
        end
      end

      assign req_sync[gi] = in_reg;
`endif
    end
  endgenerate

  logic       req_valid;
  logic [1:0] req_winner;

  // Fixed-priority resolution: lowest bit (note C) wins.
  always_comb begin
    req_valid  = |req_sync;
    req_winner = 2'd0;
    if (req_sync[0]) begin
      req_winner = 2'd0;
    end else if (req_sync[1]) begin
      req_winner = 2'd1;
    end else if (req_sync[2]) begin
      req_winner = 2'd2;
    end else if (req_sync[3]) begin
      req_winner = 2'd3;
    end
  end

  state_t      state_reg, state_next;
  logic [1:0]  sel_reg, sel_next;
  logic [12:0] cnt_reg, cnt_next;
  logic [4:0]  addr_reg, addr_next;
  logic        tick_reg, tick_next;

  logic [12:0] term_cnt;
  logic        step_wrap;
  logic [12:0] cnt_adv;
  logic [4:0]  addr_adv;

  // Divider step for the note currently playing: counter advance, address
  // advance and the wrap condition shared by PLAY and DRAIN.
  always_comb begin
    case (sel_reg)
      2'd0:    term_cnt = TC_DO;
      2'd1:    term_cnt = TC_RE;
      2'd2:    term_cnt = TC_MI;
      default: term_cnt = TC_SOL;
    endcase
    step_wrap = (cnt_reg == term_cnt);
    cnt_adv   = step_wrap ? 13'd0 : (cnt_reg + 13'd1);
    addr_adv  = step_wrap ? (addr_reg + 5'd1) : addr_reg;
  end

  // Next-state logic: PLAY drops to DRAIN on any request change, DRAIN only
  // leaves on the 31->0 wrap (or returns to PLAY if the note comes back).
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    tick_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next  = 13'd0;
        addr_next = 5'd0;
        if (req_valid) begin
          state_next = ST_PLAY;
          sel_next   = req_winner;
        end
      end
      ST_PLAY: begin
        cnt_next  = cnt_adv;
        addr_next = addr_adv;
        tick_next = step_wrap;
        if (!req_valid || (req_winner != sel_reg)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_next  = cnt_adv;
        addr_next = addr_adv;
        tick_next = step_wrap;
        if (step_wrap && (addr_reg == 5'd31)) begin
          // Period boundary: the counter and address are both wrapping to 0,
          // so a new note starts cleanly from phase 0.
          if (!req_valid) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_PLAY;
            sel_next   = req_winner;
          end
        end else if (req_valid && (req_winner == sel_reg)) begin
          state_next = ST_PLAY;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 13'd0;
        addr_next  = 5'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any note at once.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 2'd0;
      cnt_reg   <= 13'd0;
      addr_reg  <= 5'd0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      tick_reg  <= tick_next;
    end
  end

  assign rom_addr    = addr_reg;
  assign sample_tick = tick_reg;
  assign note_active = (state_reg != ST_IDLE);
  assign note_sel    = sel_reg;

endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed scenarios plus randomized requests, all checked
// cycle by cycle against a behavioural model of the note arbiter.
module tb_tone_arbiter;

`ifdef TONE_ARBITER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam int D_DO  = 4;
  localparam int D_RE  = 5;
  localparam int D_MI  = 6;
  localparam int D_SOL = 7;

  logic       clk50mhz = 1'b0;
  logic       rst      = 1'b1;
  logic       do_nota  = 1'b0;
  logic       re_nota  = 1'b0;
  logic       mi_nota  = 1'b0;
  logic       sol_nota = 1'b0;
  logic [4:0] rom_addr;
  logic       sample_tick;
  logic       note_active;
  logic [1:0] note_sel;

  tone_arbiter #(
    .DIV_DO (13'd4),
    .DIV_RE (13'd5),
    .DIV_MI (13'd6),
    .DIV_SOL(13'd7)
  ) dut (
    .clk50mhz   (clk50mhz),
    .rst        (rst),
    .do_nota    (do_nota),
    .re_nota    (re_nota),
    .mi_nota    (mi_nota),
    .sol_nota   (sol_nota),
    .rom_addr   (rom_addr),
    .sample_tick(sample_tick),
    .note_active(note_active),
    .note_sel   (note_sel)
  );

  always #5 clk50mhz = ~clk50mhz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 silent, 1 playing, 2 finishing the current period.
  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [12:0] phase;
    logic [4:0]  addr;
    logic        tick;
    logic [3:0]  p0;
    logic [3:0]  p1;
  } mstate_t;

  function automatic int divof(input logic [1:0] s);
    int d;
    case (s)
      2'd0:    d = D_DO;
      2'd1:    d = D_RE;
      2'd2:    d = D_MI;
      default: d = D_SOL;
    endcase
    return (d < 2) ? 2 : d;
  endfunction

  function automatic logic [1:0] winner(input logic [3:0] e);
    if (e[0]) return 2'd0;
    if (e[1]) return 2'd1;
    if (e[2]) return 2'd2;
    if (e[3]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [3:0] in_v, input logic r);
    mstate_t    n;
    logic [3:0] eff;
    logic       v;
    logic [1:0] w;
    logic       wrap;
    n = s;
    if (r) begin
      n = '0;
    end else begin
      eff  = (LAT == 3) ? s.p1 : s.p0;
      n.p1 = s.p0;
      n.p0 = in_v;
      v    = (eff != 4'd0);
      w    = winner(eff);
      if (s.mode == 2'd0) begin
        n.addr  = 5'd0;
        n.phase = 13'd0;
        n.tick  = 1'b0;
        if (v) begin
          n.mode = 2'd1;
          n.sel  = w;
        end
      end else begin
        wrap    = (int'(s.phase) == divof(s.sel) - 1);
        n.tick  = wrap;
        n.phase = wrap ? 13'd0 : 13'(int'(s.phase) + 1);
        n.addr  = wrap ? 5'((int'(s.addr) + 1) % 32) : s.addr;
        if (s.mode == 2'd1) begin
          if (!v || w != s.sel) n.mode = 2'd2;
        end else if (wrap && s.addr == 5'd31) begin
          if (!v) begin
            n.mode = 2'd0;
          end else begin
            n.mode = 2'd1;
            n.sel  = w;
          end
        end else if (v && w == s.sel) begin
          n.mode = 2'd1;
        end
      end
    end
    return n;
  endfunction

  mstate_t m       = '0;
  logic    m_valid = 1'b0;

  always @(posedge clk50mhz) begin
    m <= model_step(m, {sol_nota, mi_nota, re_nota, do_nota}, rst);
    if (rst) m_valid <= 1'b1;
  end

  // One cycle: wait for the falling edge, then compare every output to the model.
  task automatic step();
    @(negedge clk50mhz);
    cyc++;
    if (m_valid) begin
      checks++;
      if (int'(rom_addr) != int'(m.addr) || sample_tick != m.tick ||
          note_active != (m.mode != 2'd0) || note_sel != m.sel) begin
        errors++;
        $display("FAIL model cycle %0d actual addr=%0d tick=%0d active=%0d sel=%0d expected addr=%0d tick=%0d active=%0d sel=%0d",
                 cyc, rom_addr, sample_tick, note_active, note_sel,
                 m.addr, m.tick, (m.mode != 2'd0), m.sel);
      end
    end
  endtask

  task automatic set_req(input logic [3:0] v);
    {sol_nota, mi_nota, re_nota, do_nota} = v;
  endtask

  task automatic do_reset();
    set_req(4'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic next_tick(input int budget, output int gap);
    gap = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      gap++;
      if (sample_tick) break;
    end
    check("tick_seen", int'(sample_tick), 1);
  endtask

  task automatic wait_active(input int budget, output int k);
    k = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      k++;
      if (note_active) break;
    end
    check("active_seen", int'(note_active), 1);
  endtask

  task automatic wait_addr(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (sample_tick && int'(rom_addr) == target) break;
    end
    check("addr_reached", int'(rom_addr), target);
  endtask

  int k, gap, n, t;
  int hold;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_addr", int'(rom_addr), 0);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_active", int'(note_active), 0);
    check("rst_sel", int'(note_sel), 0);
    rst = 1'b0;
    step();
    check("idle_active", int'(note_active), 0);

    // D held from idle: latency, note code, tick spacing, full address sweep
    re_nota = 1'b1;
    wait_active(10, k);
    check("re_latency", k, LAT);
    check("re_sel", int'(note_sel), 1);
    next_tick(20, gap);
    check("re_first_gap", gap, 5);
    check("re_first_addr", int'(rom_addr), 1);
    for (int i = 2; i <= 32; i++) begin
      next_tick(20, gap);
      check("re_gap", gap, 5);
      check("re_addr", int'(rom_addr), i % 32);
    end
    check("re_still_active", int'(note_active), 1);

    // C and G together: C wins, period 4
    do_reset();
    set_req(4'b1001);
    wait_active(10, k);
    check("cg_latency", k, LAT);
    check("cg_sel", int'(note_sel), 0);
    for (int i = 0; i < 3; i++) begin
      next_tick(20, gap);
      check("cg_gap", gap, 4);
    end

    // Reset in the middle of a note at address 17
    wait_addr(17, 300);
    rst = 1'b1;
    step();
    check("midrst_addr", int'(rom_addr), 0);
    check("midrst_active", int'(note_active), 0);
    check("midrst_tick", int'(sample_tick), 0);
    rst = 1'b0;
    do_reset();

    // E playing, switch to C at address 10: E finishes its period first
    mi_nota = 1'b1;
    wait_active(10, k);
    check("mi_sel", int'(note_sel), 2);
    wait_addr(10, 400);
    mi_nota = 1'b0;
    do_nota = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_tick(20, gap);
      if (rom_addr == 5'd0) break;
      check("switch_old_gap", gap, 6);
      check("switch_old_sel", int'(note_sel), 2);
    end
    check("switch_wrap_gap", gap, 6);
    check("switch_new_sel", int'(note_sel), 0);
    check("switch_active", int'(note_active), 1);
    next_tick(20, gap);
    check("switch_new_gap", gap, 4);
    check("switch_new_addr", int'(rom_addr), 1);

    // G released at 5 and re-asserted at 8: no gap in the ticks
    do_reset();
    sol_nota = 1'b1;
    wait_active(10, k);
    for (int i = 0; i < 40; i++) begin
      next_tick(20, gap);
      check("sol_gap", gap, 7);
      check("sol_active", int'(note_active), 1);
      check("sol_sel", int'(note_sel), 3);
      if (rom_addr == 5'd5) sol_nota = 1'b0;
      if (rom_addr == 5'd8) sol_nota = 1'b1;
      if (rom_addr == 5'd12) break;
    end

    // Everything released at 20: 12 more ticks, then silent at address 0
    wait_addr(20, 300);
    sol_nota = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      next_tick(20, gap);
      n++;
      if (rom_addr == 5'd0) break;
    end
    check("drain_ticks", n, 12);
    check("drain_idle", int'(note_active), 0);
    t = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sample_tick) t++;
    end
    check("idle_no_ticks", t, 0);
    check("idle_addr", int'(rom_addr), 0);

    // Randomized request patterns with occasional resets
    for (int seg = 0; seg < 40; seg++) begin
      set_req(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 300));
      for (int i = 0; i < hold; i++) step();
    end
    set_req(4'd0);
    for (int i = 0; i < 300; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter DIV_DO, default 13'd5972: clk50mhz cycles per sample step for note C.
REQ-002 Parameter DIV_RE, default 13'd5320: cycles per sample step for note D.
REQ-003 Parameter DIV_MI, default 13'd4738: cycles per sample step for note E.
REQ-004 Parameter DIV_SOL, default 13'd3986: cycles per sample step for note G.
REQ-005 Port clk50mhz, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Ports do_nota, re_nota, mi_nota, sol_nota, each input, 1: level note requests, asynchronous to clk50mhz.
REQ-008 Port rom_addr, output, 5: sine ROM address, registered.
REQ-009 Port sample_tick, output, 1: one-cycle pulse in the cycle rom_addr advances.
REQ-010 Port note_active, output, 1: high while state is not IDLE.
REQ-011 Port note_sel, output, 2: playing note, 0=C, 1=D, 2=E, 3=G.

Function
REQ-012 Requests SHALL be resolved by fixed priority do > re > mi > sol into winner w and valid v.
REQ-013 FSM states SHALL be IDLE, PLAY and DRAIN; note changes SHALL occur only at waveform period boundaries.
REQ-014 IDLE: rom_addr=0, 13-bit divider counter=0, sample_tick=0; when v=1, the next state SHALL be PLAY with note_sel=w and counter=0.
REQ-015 PLAY/DRAIN: the counter SHALL increment each cycle, and at counter==DIV(note_sel)-1 it SHALL return to 0 and rom_addr SHALL increment modulo 32, with sample_tick high that cycle.
REQ-016 First tick after entering PLAY from IDLE SHALL occur DIV(note_sel) cycles after entry.
REQ-017 PLAY SHALL go to DRAIN when v=0 or w!=note_sel.
REQ-018 DRAIN SHALL return to PLAY, with no counter/address disturbance, if v=1 and w==note_sel.
REQ-019 DRAIN on the tick wrapping rom_addr 31->0: if v=0 go IDLE, else go PLAY with note_sel=w and counter=0.
REQ-020 A request change in the same cycle as a wrap tick in PLAY SHALL enter DRAIN, completing one further full period.
REQ-021 Parameter values below 2 SHALL be treated as 2.

Reset
REQ-022 While rst=1 at a rising edge, the state SHALL become IDLE and rom_addr=0, sample_tick=0, note_active=0, note_sel=0, counter=0, synchronizer flops=0.
REQ-023 Reset mid-note SHALL abort immediately with no drain period.

Configuration
REQ-024 Macro TONE_ARBITER_SYNC_EN defined: each note input SHALL pass through a two-flop synchronizer, making request-to-PLAY latency 3 cycles.
REQ-025 Macro not defined: inputs SHALL be registered once, making request-to-PLAY latency 2 cycles; all other behaviour identical.

Verification (DIV_DO=4, DIV_RE=5, DIV_MI=6, DIV_SOL=7, macro defined)
REQ-026 Reset mid-PLAY at rom_addr=17 -> next cycle IDLE, rom_addr=0, note_active=0.
REQ-027 re_nota held from IDLE -> note_active high 3 cycles later, note_sel=1, ticks every 5 cycles, rom_addr 0..31 wrapping to 0.
REQ-028 do_nota and sol_nota asserted together -> note_sel=0, tick period 4.
REQ-029 mi playing, switch to do_nota at rom_addr=10 -> mi continues to 31->0 wrap, then note_sel=0 and the next tick 4 cycles later.
REQ-030 sol released at rom_addr=5 and reasserted at rom_addr=8 -> no gap, tick spacing stays 7, state PLAY.
REQ-031 All requests dropped at rom_addr=20 -> 12 more ticks, then IDLE at rom_addr=0, sample_tick stays 0.
